// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: imem address/data plus the instruction-register outputs that feed decode.
interface fetch_unit_if #(
  parameter int unsigned PC_W    = 6,
  parameter int unsigned INSTR_W = 32
);
  localparam int unsigned CNT_W = 16;

  logic               stall;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic [INSTR_W-1:0] imem_instr;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] instr_out;
  logic [PC_W-1:0]    pc_out;
  logic               instr_valid;
  logic               halted;
  logic [CNT_W-1:0]   fetch_count;

  modport master (
    input  stall, branch_taken, branch_target, imem_instr,
    output imem_addr, instr_out, pc_out, instr_valid, halted, fetch_count
  );

  modport slave (
    output stall, branch_taken, branch_target, imem_instr,
    input  imem_addr, instr_out, pc_out, instr_valid, halted, fetch_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, registers the imem word for decode, and handles
// stall, branch redirect with a one-bubble squash, halt detection and a saturating count.
module fetch_unit #(
  parameter int unsigned        PC_W      = 6,
  parameter int unsigned        INSTR_W   = 32,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] HALT_WORD = '1
) (
  input logic           clk,
  input logic           reset,
  fetch_unit_if.master  bus
);
  localparam int unsigned CNT_W = 16;

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_out_q, pc_out_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Next-state: branch beats stall beats normal fetch; HALT only drops valid.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    count_d  = count_q;
    case (state_q)
      S_RUN: begin
        if (bus.branch_taken) begin
          pc_d    = {bus.branch_target[PC_W-1:1], 1'b0};
          valid_d = 1'b0;
        end else if (!bus.stall) begin
          instr_d  = bus.imem_instr;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          if (count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
          // Halt word is issued but the PC parks on it.
          if (bus.imem_instr == HALT_WORD) state_d = S_HALT;
          else                              pc_d    = pc_q + PC_W'(2);
        end
      end
      S_HALT: valid_d = 1'b0;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_RUN;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.instr_out   = instr_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.instr_valid = valid_q;
  assign bus.fetch_count = count_q;
  assign bus.halted      = (state_q == S_HALT);
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of `decode` in `cpu`. It owns the 6-bit program counter (PC), drives the address into the combinational `instr_mem`, and registers the returned 32-bit word into an instruction register for decode. It handles stall, taken-branch redirect with squash, halt detection and a saturating fetch counter.

## Interface
- `PC_W`, default 6: program counter width.
- `INSTR_W`, default 32: instruction width.
- `RESET_PC`, default 0: PC value loaded on reset.
- `HALT_WORD`, default 32'hFFFF_FFFF: instruction encoding that halts fetch.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `stall`, input, 1: downstream not ready; hold all fetch state.
- `branch_taken`, input, 1: redirect request.
- `branch_target`, input, PC_W: redirect address; bit 0 is ignored and forced to 0.
- `imem_instr`, input, INSTR_W: word returned combinationally by `instr_mem` for `imem_addr`.
- `imem_addr`, output, PC_W: equals the PC register (combinational from the register).
- `instr_out`, output, INSTR_W: instruction register, feeds `decode.instr`.
- `pc_out`, output, PC_W: address of the word in `instr_out`.
- `instr_valid`, output, 1: `instr_out` holds a live instruction.
- `halted`, output, 1: high while in HALT.
- `fetch_count`, output, 16: number of valid instructions issued; saturates at 16'hFFFF.

## Operation
- States: RUN and HALT.
- Reset values (any state, any input): PC=RESET_PC, `instr_out`=0, `pc_out`=0, `instr_valid`=0, `halted`=0, `fetch_count`=0, state=RUN.
- Edge priority, highest first: reset, then branch, then stall, then normal fetch.
- RUN, branch_taken=1 (stall ignored):
  - PC <= {branch_target[PC_W-1:1],1'b0}.
  - `instr_valid` <= 0; the word fetched this cycle is squashed.
  - `instr_out` and `pc_out` hold.
  - `fetch_count` unchanged.
- RUN, stall=1, branch_taken=0: PC, `instr_out`, `pc_out`, `instr_valid`, `fetch_count` all hold.
- RUN, normal fetch:
  - `instr_out` <= `imem_instr`, `pc_out` <= PC, `instr_valid` <= 1.
  - `fetch_count` increments, saturating.
  - PC <= PC+2 modulo 2^PC_W, so 62 wraps to 0.
- Halt detection: on a normal-fetch edge where `imem_instr`==HALT_WORD:
  - The halt word is still issued (`instr_valid`=1, counted).
  - PC is NOT advanced.
  - State <= HALT.
- HALT:
  - `halted`=1.
  - On the first HALT edge, `instr_valid` <= 0; it stays 0 afterwards.
  - PC, `instr_out`, `pc_out`, `fetch_count` frozen.
  - `branch_taken` and `stall` are ignored. Only reset exits HALT.
- A halt word arriving on a branch or stall edge does not trigger HALT; it is squashed or held instead.

## Timing
- `imem_addr` changes only at clock edges (registered PC).
- Fetch latency is 1 cycle: the word at PC appears on `instr_out` after the next rising edge.
- Steady-state throughput: one instruction per cycle.
- Branch penalty: 1 bubble cycle.
  - Redirect asserted in cycle N gives `instr_valid`=0 after edge N.
  - The target instruction is valid after edge N+1.
- Stall is level-sensitive. Outputs are unchanged for every stalled edge, and fetch resumes on the first unstalled edge with no lost or duplicated instruction.
- Reset asserted mid-operation (including in HALT or during a stall) takes effect at that edge.
  - The first valid instruction (word at RESET_PC) appears one edge after reset deasserts.
- `halted` rises on the same edge that the halt word appears on `instr_out`.

## Test plan
- **Reset then free-run**, mem[0,2,4] = A, B, C:
  - After reset, successive edges give (`pc_out`, `instr_out`) = (0,A), (2,B), (4,C).
  - `instr_valid`=1 and `fetch_count`=1,2,3.
- **PC wrap**, RESET_PC=60, no halt words in memory:
  - `pc_out` sequence 60, 62, 0, 2.
  - `imem_addr` goes 62 → 0 with no glitch cycle.
- **Stall for 3 cycles** after the fetch at PC=4:
  - `instr_out`, `pc_out`=4 and `fetch_count` hold for 3 edges.
  - The next edge issues PC=6; no duplicate and no skip.
- **branch_taken with stall=1, target=6'd13**, asserted while PC=8:
  - Next edge: `instr_valid`=0, PC=12.
  - Following edge: `pc_out`=12, `instr_valid`=1.
  - `fetch_count` skips the squashed word.
- **mem[6]=32'hFFFF_FFFF**:
  - Edge issuing PC=6 gives `instr_valid`=1 and `halted`=1.
  - Next edge `instr_valid`=0. `imem_addr` stays 6 for 10 cycles despite `branch_taken` pulses.
- **Reset while halted**:
  - All outputs return to reset values on that edge.
  - Normal fetch from RESET_PC resumes.
